// File: rtl/sum_stage_fifo.sv
// rtl/sum_stage_fifo.sv - FWFT buffer for adder sums with full-drop accounting.
// Samples in_data on in_strobe; drops (and counts) strobes that find the FIFO full.
module sum_stage_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_strobe,
  input  logic                     flush,
  input  logic                     clr_stats,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic              drop;

  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign out_data  = mem[rd_ptr];

  // A pop in the same cycle frees the slot a full FIFO needs to accept a strobe.
  assign pop  = out_valid & out_ready;
  assign push = in_strobe & (~full | pop) & ~flush;
  assign drop = in_strobe & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  // clr_stats takes priority over a coincident drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_stats) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sum_stage_fifo.sv
// tb/tb_sum_stage_fifo.sv - directed self-checking bench for sum_stage_fifo.
module tb_sum_stage_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_strobe;
  logic       flush;
  logic       clr_stats;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  sum_stage_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_strobe(in_strobe),
    .flush(flush), .clr_stats(clr_stats), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_drop"}, 32'(drop_cnt), 0);
  endtask

  initial begin
    logic [7:0] t1 [3];
    logic [7:0] t2 [5];
    t1 = '{8'h11, 8'h22, 8'h33};
    t2 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};

    rst = 1'b1; in_data = '0; in_strobe = 0; flush = 0; clr_stats = 0; out_ready = 0;
    step(); step();
    rst = 1'b0;
    chk_reset_state("reset");

    // basic push then ordered pop
    in_strobe = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = t1[i];
      step();
      chk("t1_count", 32'(count), 32'(i + 1));
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_head", 32'(out_data), 32'h11);
    end
    in_strobe = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop", 32'(out_data), 32'(t1[i]));
      step();
    end
    chk("t1_empty_count", 32'(count), 0);
    chk("t1_empty_valid", 32'(out_valid), 0);

    // fill, drop, then full-with-pop accept
    out_ready = 0; in_strobe = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = t2[i];
      step();
    end
    chk("t2_full", 32'(full), 1);
    chk("t2_ovf_pre", 32'(overflow), 0);
    in_data = 8'hFF;
    step();
    chk("t2_drop_full", 32'(full), 1);
    chk("t2_drop_ovf", 32'(overflow), 1);
    chk("t2_drop_cnt", 32'(drop_cnt), 1);
    chk("t2_drop_count", 32'(count), 4);
    chk("t2_drop_head", 32'(out_data), 32'hA0);
    in_data = 8'hB0; out_ready = 1;
    step();
    chk("t2_accept_count", 32'(count), 4);
    chk("t2_accept_drop", 32'(drop_cnt), 1);
    in_strobe = 0;
    for (int i = 1; i < 5; i++) begin
      chk("t2_pop", 32'(out_data), 32'(t2[i]));
      step();
    end
    chk("t2_empty", 32'(count), 0);

    // streaming: push and pop every cycle, pointers wrap several times
    in_strobe = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(i + 8'h40);
      step();
      chk("t3_data", 32'(out_data), 32'(i + 8'h40));
      chk("t3_count", 32'(count), 1);
    end
    in_strobe = 0;
    step();
    chk("t3_drain", 32'(count), 0);

    // saturating drop counter, then clr_stats with a coincident drop
    out_ready = 0; in_strobe = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hC0 + i);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      in_data = 8'(i);
      step();
      if (i == 253) chk("t4_cnt_254", 32'(drop_cnt), 255);
    end
    chk("t4_sat", 32'(drop_cnt), 255);
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_head", 32'(out_data), 32'hC0);
    clr_stats = 1;
    step();
    clr_stats = 0;
    chk("t4_clr_ovf", 32'(overflow), 0);
    chk("t4_clr_cnt", 32'(drop_cnt), 0);
    step();
    chk("t4_redrop", 32'(drop_cnt), 1);

    // flush while full with strobe: not a drop
    flush = 1;
    step();
    flush = 0;
    chk("t5_flush_full_count", 32'(count), 0);
    chk("t5_flush_full_drop", 32'(drop_cnt), 1);
    for (int i = 1; i <= 3; i++) begin
      in_data = 8'(i);
      step();
    end
    chk("t5_three", 32'(count), 3);
    flush = 1; out_ready = 1; in_data = 8'h44;
    step();
    flush = 0; out_ready = 0;
    chk("t5_flush_count", 32'(count), 0);
    chk("t5_flush_valid", 32'(out_valid), 0);
    chk("t5_flush_drop", 32'(drop_cnt), 1);
    chk("t5_flush_ovf", 32'(overflow), 1);
    in_data = 8'h5A;
    step();
    chk("t5_new_data", 32'(out_data), 32'h5A);
    chk("t5_new_count", 32'(count), 1);

    // asynchronous reset mid-cycle
    in_data = 8'h5B;
    step();
    chk("t6_pre_count", 32'(count), 2);
    #2 rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    in_strobe = 0;
    step();
    rst = 1'b0;
    in_strobe = 1; in_data = 8'h66;
    step();
    chk("t6_restart_data", 32'(out_data), 32'h66);
    chk("t6_restart_count", 32'(count), 1);
    in_strobe = 0; out_ready = 1;
    step();
    chk("t6_restart_empty", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
